line_buffer_reader: RTL and testbench

LINE_BUFFER_READER -- requirements
Module: line_buffer_reader

---
 rtl/line_buffer_reader.sv | 100 ++++++++++
 tb/tb_line_buffer_reader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_reader.sv
// Line buffer FIFO with a combinational read port (rd_data = storage[rd_ptr]).
// Optional sticky overflow flag: define LINE_BUFFER_OVERFLOW_FLAG_EN.
module line_buffer_reader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [3:0]        count,
    output logic              full,
    output logic              empty
`ifdef LINE_BUFFER_OVERFLOW_FLAG_EN
    ,
    output logic              overflow
`endif
);

    localparam int unsigned PTR_W = 4;
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_wr_en;
    logic w_rd_en;

    // Flags decode registered count only; a full buffer drops a write even if a read frees space.
    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);
    assign w_wr_en = data_valid && !w_full;
    assign w_rd_en = rd_ready && !w_empty;

    assign full     = w_full;
    assign empty    = w_empty;
    assign wr_ready = !w_full;
    assign rd_valid = !w_empty;
    assign count    = r_count;
    assign rd_data  = r_mem[r_rd_ptr];

    // Storage is never cleared, not even by reset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_wr_en) begin
            r_wr_ptr <= (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_rd_en) begin
            r_rd_ptr <= (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + PTR_W'(1);
                2'b01:   r_count <= r_count - PTR_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef LINE_BUFFER_OVERFLOW_FLAG_EN
    logic r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (data_valid && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow = r_overflow;
`endif

endmodule

// File: tb/tb_line_buffer_reader.sv
// Directed scoreboard bench for line_buffer_reader (default DATA_W=8, DEPTH=11).
module tb_line_buffer_reader;

    localparam int DEPTH = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = '0;
    logic       data_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [3:0] count;
    logic       full;
    logic       empty;
`ifdef LINE_BUFFER_OVERFLOW_FLAG_EN
    logic       overflow;
    logic       ovf_exp = 1'b0;
`endif

    int         n_vec = 0;
    int         n_err = 0;
    int         m_cnt = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_d;

    always #5 clk = ~clk;

    line_buffer_reader dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .count      (count),
        .full       (full),
        .empty      (empty)
`ifdef LINE_BUFFER_OVERFLOW_FLAG_EN
        ,
        .overflow   (overflow)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; inputs change 1 time unit after a rising edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic r);
        logic acc_wr;
        logic acc_rd;
        data_valid = v;
        data_in    = d;
        rd_ready   = r;
        acc_wr = v && (m_cnt < DEPTH);
        acc_rd = r && (m_cnt > 0);
        #1;
        if (acc_rd) begin
            exp_d = sb.pop_front();
            chk("rd_data_pop", 32'(rd_data), 32'(exp_d));
        end
        if (acc_wr) sb.push_back(d);
        if (acc_wr && !acc_rd) m_cnt++;
        if (acc_rd && !acc_wr) m_cnt--;
`ifdef LINE_BUFFER_OVERFLOW_FLAG_EN
        if (v && m_cnt == DEPTH && !acc_rd && !acc_wr) ovf_exp = 1'b1;
        if (v && !acc_wr) ovf_exp = 1'b1;
`endif
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        rd_ready   = 1'b0;
        chk("count", 32'(count), 32'(m_cnt));
        chk("rd_valid", 32'(rd_valid), 32'(m_cnt != 0));
`ifdef LINE_BUFFER_OVERFLOW_FLAG_EN
        chk("overflow", 32'(overflow), 32'(ovf_exp));
`endif
    endtask

    task automatic do_reset(input int n);
        rst        = 1'b1;
        data_valid = 1'b1;
        rd_ready   = 1'b1;
        data_in    = 8'hEE;
        repeat (n) @(posedge clk);
        #1;
        rst        = 1'b0;
        data_valid = 1'b0;
        rd_ready   = 1'b0;
        sb.delete();
        m_cnt = 0;
`ifdef LINE_BUFFER_OVERFLOW_FLAG_EN
        ovf_exp = 1'b0;
`endif
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        // Basic stream
        do_reset(3);
        cyc(1'b1, 8'd10, 1'b0);
        cyc(1'b1, 8'd20, 1'b0);
        chk("basic_count2", 32'(count), 32'd2);
        chk("basic_head10", 32'(rd_data), 32'd10);
        chk("basic_valid", 32'(rd_valid), 32'd1);
        cyc(1'b0, 8'd0, 1'b1);
        chk("basic_head20", 32'(rd_data), 32'd20);
        chk("basic_count1", 32'(count), 32'd1);

        // Gapped valid: 30 and 40 are never written
        cyc(1'b0, 8'd30, 1'b0);
        cyc(1'b0, 8'd40, 1'b0);
        cyc(1'b1, 8'd50, 1'b0);
        cyc(1'b0, 8'd0, 1'b1);
        chk("gap_head50", 32'(rd_data), 32'd50);
        cyc(1'b0, 8'd0, 1'b1);
        chk("gap_empty", 32'(empty), 32'd1);

        // Fill, overflow attempt, drain and wrap from pointer 10 to 0
        do_reset(1);
        for (int i = 1; i <= DEPTH; i++) cyc(1'b1, 8'(i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_wr_ready", 32'(wr_ready), 32'd0);
        chk("fill_count", 32'(count), 32'(DEPTH));
        cyc(1'b1, 8'd99, 1'b0);
        chk("drop_count", 32'(count), 32'(DEPTH));
        chk("drop_head1", 32'(rd_data), 32'd1);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'd0, 1'b1);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_sb", 32'(sb.size()), 32'd0);
        cyc(1'b1, 8'd7, 1'b0);
        chk("wrap_head7", 32'(rd_data), 32'd7);
        chk("wrap_wr_ptr", 32'(dut.r_wr_ptr), 32'd1);
        cyc(1'b0, 8'd0, 1'b1);

        // Simultaneous events: empty, mid-level, full
        cyc(1'b1, 8'd5, 1'b1);
        chk("sim_empty_count", 32'(count), 32'd1);
        chk("sim_empty_head", 32'(rd_data), 32'd5);
        cyc(1'b1, 8'd6, 1'b0);
        cyc(1'b1, 8'd8, 1'b0);
        cyc(1'b1, 8'd9, 1'b1);
        chk("sim_mid_count", 32'(count), 32'd3);
        chk("sim_mid_head", 32'(rd_data), 32'd6);
        repeat (3) cyc(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(100 + i), 1'b0);
        cyc(1'b1, 8'd77, 1'b1);
        chk("sim_full_count", 32'(count), 32'(DEPTH - 1));
        chk("sim_full_head", 32'(rd_data), 32'd101);
        for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 8'd0, 1'b1);
        chk("sim_full_empty", 32'(empty), 32'd1);

        // Reset mid-stream with four entries stored
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(60 + i), 1'b0);
        chk("mid_count4", 32'(count), 32'd4);
        do_reset(1);
        cyc(1'b1, 8'd42, 1'b0);
        chk("post_rst_head", 32'(rd_data), 32'd42);
        chk("post_rst_valid", 32'(rd_valid), 32'd1);
        cyc(1'b0, 8'd0, 1'b1);

        // Read attempts while empty leave rd_ptr at 1
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'd0, 1'b1);
            chk("empty_rd_ptr", 32'(dut.r_rd_ptr), 32'd1);
        end
        cyc(1'b1, 8'd3, 1'b0);
        chk("empty_then_head", 32'(rd_data), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
